// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame data width and the
// default bit period used by both the transmitter and async_receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // 25 MHz clock / 432 clocks per bit gives a 17280 ns bit time
  localparam int DEFAULT_CLKS_PER_BIT = 432;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write port of the buffered transmitter: valid/ready handshake plus data.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a separate occupancy counter; pushes are refused while
// full, even when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter: a byte FIFO feeds a start/data/stop serializer that
// sends frames back-to-back while bytes are queued; TxD is a registered output.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_buffered_if.slave    wr,
  output logic                 TxD,
  output logic                 TxD_busy,
  output logic [CW-1:0]        fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  tx_state_t            state;
  tx_state_t            next_state;
  logic [BW-1:0]        baud_cnt;
  logic [BW-1:0]        baud_d;
  logic [IW-1:0]        bit_idx;
  logic [IW-1:0]        idx_d;
  logic [IW-1:0]        idx_next;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] head;
  logic                 txd_q;
  logic                 txd_d;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 bit_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign bit_done    = (baud_cnt == BAUD_LAST);
  assign idx_next    = bit_idx + IW'(1);
  assign wr.wr_ready = !full;
  assign TxD         = txd_q;
  assign TxD_busy    = (state != IDLE) || !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = START;
      START:   if (bit_done) next_state = DATA;
      DATA:    if (bit_done && bit_idx == DATA_LAST) next_state = STOP;
      STOP:    if (bit_done && bit_idx == STOP_LAST) next_state = empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // bit_idx counts data bits in DATA and stop bits in STOP; the next TxD level
  // is computed here so the line itself comes straight from a flop
  always_comb begin
    pop    = 1'b0;
    txd_d  = txd_q;
    baud_d = bit_done ? '0 : baud_cnt + BW'(1);
    idx_d  = bit_idx;
    case (state)
      IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        txd_d  = 1'b1;
        if (!empty) begin
          pop   = 1'b1;
          txd_d = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d = '0;
          txd_d = sh[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == DATA_LAST) begin
            idx_d = '0;
            txd_d = 1'b1;
          end else begin
            idx_d = idx_next;
            txd_d = sh[idx_next];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_idx == STOP_LAST) begin
            idx_d = '0;
            if (!empty) begin
              pop   = 1'b1;
              txd_d = 1'b0;
            end
          end else begin
            idx_d = idx_next;
          end
        end
      end
      default: begin
        baud_d = '0;
        idx_d  = '0;
        txd_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      txd_q    <= 1'b1;
    end else begin
      baud_cnt <= baud_d;
      bit_idx  <= idx_d;
      txd_q    <= txd_d;
      if (pop) begin
        sh <= head;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a default-timing instance and a fast
// instance (4 clocks per bit, 2 stop bits), each watched by a frame monitor.
module tb_uart_tx_buffered;

  localparam int CPB1 = 432;
  localparam int F1   = 4320;
  localparam int CPB2 = 4;
  localparam int F2   = 44;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txd1, busy1, txd2, busy2;
  logic [2:0] cnt1, cnt2;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q1[$];
  exp_t       q2[$];

  uart_tx_buffered_if if1 ();
  uart_tx_buffered_if if2 ();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .wr(if1.slave), .TxD(txd1), .TxD_busy(busy1), .fifo_count(cnt1)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .wr(if2.slave), .TxD(txd2), .TxD_busy(busy2), .fifo_count(cnt2)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level p cycles into a frame: start, 8 data bits LSB first, stop
  function automatic logic exp_bit(input logic [7:0] d, input int p, input int cpb);
    int b;
    b = p / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit sel, input logic [7:0] d, output int edge_n);
    if (sel) begin
      if2.wr_valid = 1'b1;
      if2.wr_data  = d;
    end else begin
      if1.wr_valid = 1'b1;
      if1.wr_data  = d;
    end
    @(posedge clk);
    #1;
    edge_n = cyc;
  endtask

  task automatic release_bus();
    if1.wr_valid = 1'b0;
    if2.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? busy2 : busy1) == 1'b0) begin
        t = cyc;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (txd1 !== 1'b1) lows++;
    end
    check_output(name, lows, 0);
  endtask

  bit   in1 = 1'b0, ghost1 = 1'b0;
  int   st1, bad1;
  exp_t cur1;

  always @(negedge clk) begin
    if (!rst) begin
      in1 = 1'b0;
    end else begin
      if (!in1 && txd1 === 1'b0) begin
        in1 = 1'b1; st1 = cyc; bad1 = 0; ghost1 = (q1.size() == 0);
        checks++;
        if (ghost1) begin
          errors++;
          $display("[TB] FAIL unexpected_frame dut1: start at cycle %0d, none expected", cyc);
        end else begin
          cur1 = q1.pop_front();
          if (cyc != cur1.start) begin
            errors++;
            $display("[TB] FAIL start_cycle dut1 byte %h: got %0d, expected %0d", cur1.data, cyc, cur1.start);
          end
        end
      end
      if (in1) begin
        if (!ghost1 && txd1 !== exp_bit(cur1.data, cyc - st1, CPB1)) bad1++;
        if (cyc - st1 == F1 - 1) begin
          in1 = 1'b0;
          if (!ghost1) begin
            checks++;
            if (bad1 != 0) begin
              errors++;
              $display("[TB] FAIL frame_bits dut1 byte %h: %0d wrong samples, expected 0", cur1.data, bad1);
            end
          end
        end
      end
    end
  end

  bit   in2 = 1'b0, ghost2 = 1'b0;
  int   st2, bad2;
  exp_t cur2;

  always @(negedge clk) begin
    if (!rst) begin
      in2 = 1'b0;
    end else begin
      if (!in2 && txd2 === 1'b0) begin
        in2 = 1'b1; st2 = cyc; bad2 = 0; ghost2 = (q2.size() == 0);
        checks++;
        if (ghost2) begin
          errors++;
          $display("[TB] FAIL unexpected_frame dut2: start at cycle %0d, none expected", cyc);
        end else begin
          cur2 = q2.pop_front();
          if (cyc != cur2.start) begin
            errors++;
            $display("[TB] FAIL start_cycle dut2 byte %h: got %0d, expected %0d", cur2.data, cyc, cur2.start);
          end
        end
      end
      if (in2) begin
        if (!ghost2 && txd2 !== exp_bit(cur2.data, cyc - st2, CPB2)) bad2++;
        if (cyc - st2 == F2 - 1) begin
          in2 = 1'b0;
          if (!ghost2) begin
            checks++;
            if (bad2 != 0) begin
              errors++;
              $display("[TB] FAIL frame_bits dut2 byte %h: %0d wrong samples, expected 0", cur2.data, bad2);
            end
          end
        end
      end
    end
  end

  initial begin
    int n, e, t;
    logic [7:0] b;
    if1.wr_valid = 1'b0; if1.wr_data = '0;
    if2.wr_valid = 1'b0; if2.wr_data = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_output("reset_txd", txd1, 1);
    check_output("reset_busy", busy1, 0);
    check_output("reset_ready", if1.wr_ready, 1);
    check_output("reset_count", cnt1, 0);
    idle_check("idle_after_reset", 1000);

    $display("[TB] single byte 58");
    apply_stimulus(1'b0, 8'h58, n);
    release_bus();
    q1.push_back('{8'h58, n + 1});
    check_output("count_after_write", cnt1, 1);
    wait_idle(1'b0, 6000, t);
    check_output("busy_fall_single", t, n + 1 + F1);

    $display("[TB] back-to-back A5 3C");
    apply_stimulus(1'b0, 8'hA5, n);
    q1.push_back('{8'hA5, n + 1});
    apply_stimulus(1'b0, 8'h3C, e);
    release_bus();
    q1.push_back('{8'h3C, n + 1 + F1});
    wait_idle(1'b0, 12000, t);
    check_output("busy_fall_b2b", t, n + 1 + 2 * F1);

    $display("[TB] fifo full 01..06");
    apply_stimulus(1'b0, 8'h01, n);
    q1.push_back('{8'h01, n + 1});
    for (int k = 1; k < 5; k++) begin
      b = 8'(k + 1);
      apply_stimulus(1'b0, b, e);
      q1.push_back('{b, n + 1 + k * F1});
      if (k == 1) check_output("count_push_pop", cnt1, 1);
    end
    check_output("count_full", cnt1, 4);
    check_output("ready_full", if1.wr_ready, 0);
    apply_stimulus(1'b0, 8'h06, e);
    release_bus();
    check_output("count_drop", cnt1, 4);
    wait_idle(1'b0, 30000, t);
    check_output("busy_fall_full", t, n + 1 + 5 * F1);

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b0, 8'hFF, n);
    q1.push_back('{8'hFF, n + 1});
    apply_stimulus(1'b0, 8'h11, e);
    apply_stimulus(1'b0, 8'h22, e);
    release_bus();
    while (cyc < n + 1 + 4 * CPB1 + 200) begin
      @(posedge clk);
      #1;
    end
    check_output("txd_before_reset", txd1, 1);
    rst = 1'b0;
    #1;
    check_output("reset_async_txd", txd1, 1);
    check_output("reset_async_count", cnt1, 0);
    check_output("reset_async_busy", busy1, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle_check("idle_after_midreset", 1000);
    check_output("queue_after_midreset", q1.size(), 0);

    $display("[TB] fast instance 80 C3");
    apply_stimulus(1'b1, 8'h80, n);
    q2.push_back('{8'h80, n + 1});
    apply_stimulus(1'b1, 8'hC3, e);
    release_bus();
    q2.push_back('{8'hC3, n + 1 + F2});
    wait_idle(1'b1, 200, t);
    check_output("busy_fall_fast", t, n + 1 + 2 * F2);

    repeat (5) @(posedge clk);
    check_output("queue1_empty", q1.size(), 0);
    check_output("queue2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
